// File: rtl/rcc_pkg.sv
// Shared definitions for the bus clock prescaler: divide-code constants,
// code-to-divisor decoders and the reprogramming handshake states.
package rcc_pkg;

    // 4-bit divide codes (CPU and AHB prescalers)
    localparam logic [3:0] RCC_DIV1   = 4'h0;
    localparam logic [3:0] RCC_DIV2   = 4'h8;
    localparam logic [3:0] RCC_DIV4   = 4'h9;
    localparam logic [3:0] RCC_DIV8   = 4'hA;
    localparam logic [3:0] RCC_DIV16  = 4'hB;
    localparam logic [3:0] RCC_DIV64  = 4'hC;
    localparam logic [3:0] RCC_DIV128 = 4'hD;
    localparam logic [3:0] RCC_DIV256 = 4'hE;
    localparam logic [3:0] RCC_DIV512 = 4'hF;

    // 3-bit divide codes (APB prescalers)
    localparam logic [2:0] RCC_PDIV1  = 3'h0;
    localparam logic [2:0] RCC_PDIV2  = 3'h4;
    localparam logic [2:0] RCC_PDIV4  = 3'h5;
    localparam logic [2:0] RCC_PDIV8  = 3'h6;
    localparam logic [2:0] RCC_PDIV16 = 3'h7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } rcc_state_e;

    // 4-bit code to divisor (1..512); note there is no /32 setting
    function automatic logic [9:0] rcc_div4(input logic [3:0] code);
        logic [9:0] div;
        case (code)
            4'h8:    div = 10'd2;
            4'h9:    div = 10'd4;
            4'hA:    div = 10'd8;
            4'hB:    div = 10'd16;
            4'hC:    div = 10'd64;
            4'hD:    div = 10'd128;
            4'hE:    div = 10'd256;
            4'hF:    div = 10'd512;
            default: div = 10'd1;
        endcase
        return div;
    endfunction

    // 4-bit code to counter terminal value (divisor - 1)
    function automatic logic [8:0] rcc_term4(input logic [3:0] code);
        logic [9:0] t;
        t = rcc_div4(code) - 10'd1;
        return t[8:0];
    endfunction

    // 3-bit code to divisor (1..16)
    function automatic logic [4:0] rcc_div3(input logic [2:0] code);
        logic [4:0] div;
        case (code)
            3'h4:    div = 5'd2;
            3'h5:    div = 5'd4;
            3'h6:    div = 5'd8;
            3'h7:    div = 5'd16;
            default: div = 5'd1;
        endcase
        return div;
    endfunction

    // 3-bit code to counter terminal value (divisor - 1)
    function automatic logic [3:0] rcc_term3(input logic [2:0] code);
        logic [4:0] t;
        t = rcc_div3(code) - 5'd1;
        return t[3:0];
    endfunction

endpackage

// File: rtl/rcc_bus_clk_prescaler_div_stage.sv
// One prescaler stage: counts parent ticks and emits a tick on the parent
// tick that lands on the terminal count. A terminal of 0 passes ticks through.
module rcc_div_stage #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic [CNT_W-1:0] term,
    input  logic             clr,
    output logic             tick_out,
    output logic [CNT_W-1:0] cnt
);

    logic at_term;

    assign at_term  = (cnt == term);
    assign tick_out = tick_in & at_term;

    // Count parent ticks, wrapping at the terminal; clr restarts the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick_in) begin
            cnt <= at_term ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rcc_bus_clk_prescaler.sv
// Bus/CPU clock-enable prescaler. Produces nested one-cycle strobes for the
// CPU, AHB, APB1..4 and timer domains; new ratios are swapped in only at a
// frame boundary where all bus strobes coincide.
module rcc_bus_clk_prescaler
    import rcc_pkg::*;
#(
    parameter logic [3:0] RST_CPRE = 4'h0,
    parameter logic [3:0] RST_HPRE = 4'h0,
    parameter logic [2:0] RST_PPRE = 3'h0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       cfg_valid,
    input  logic [3:0] cfg_cpre,
    input  logic [3:0] cfg_hpre,
    input  logic [2:0] cfg_ppre1,
    input  logic [2:0] cfg_ppre2,
    input  logic [2:0] cfg_ppre3,
    input  logic [2:0] cfg_ppre4,
    output logic       cfg_busy,
    output logic       cfg_ack,
    output logic       cpu_clk_en,
    output logic       ahb_clk_en,
    output logic       apb1_clk_en,
    output logic       apb2_clk_en,
    output logic       apb3_clk_en,
    output logic       apb4_clk_en,
    output logic       tim_clk_en
);

    rcc_state_e state, state_next;
    logic       capture, apply, boundary;

    logic [3:0] act_cpre, act_hpre, shd_cpre, shd_hpre;
    logic [2:0] act_ppre1, act_ppre2, act_ppre3, act_ppre4;
    logic [2:0] shd_ppre1, shd_ppre2, shd_ppre3, shd_ppre4;

    logic [8:0] cpu_term, ahb_term, cpu_cnt, ahb_cnt;
    logic [3:0] apb1_term, apb2_term, apb3_term, apb4_term;
    logic [3:0] apb1_cnt, apb2_cnt, apb3_cnt, apb4_cnt;
    logic [3:0] tim_mask;

    assign cpu_term  = rcc_term4(act_cpre);
    assign ahb_term  = rcc_term4(act_hpre);
    assign apb1_term = rcc_term3(act_ppre1);
    assign apb2_term = rcc_term3(act_ppre2);
    assign apb3_term = rcc_term3(act_ppre3);
    assign apb4_term = rcc_term3(act_ppre4);

    rcc_div_stage #(.CNT_W(9)) u_cpu (
        .clk(sys_clk), .rst_n(sys_rst_n), .tick_in(1'b1), .term(cpu_term),
        .clr(apply), .tick_out(cpu_clk_en), .cnt(cpu_cnt)
    );

    rcc_div_stage #(.CNT_W(9)) u_ahb (
        .clk(sys_clk), .rst_n(sys_rst_n), .tick_in(cpu_clk_en), .term(ahb_term),
        .clr(apply), .tick_out(ahb_clk_en), .cnt(ahb_cnt)
    );

    rcc_div_stage #(.CNT_W(4)) u_apb1 (
        .clk(sys_clk), .rst_n(sys_rst_n), .tick_in(ahb_clk_en), .term(apb1_term),
        .clr(apply), .tick_out(apb1_clk_en), .cnt(apb1_cnt)
    );

    rcc_div_stage #(.CNT_W(4)) u_apb2 (
        .clk(sys_clk), .rst_n(sys_rst_n), .tick_in(ahb_clk_en), .term(apb2_term),
        .clr(apply), .tick_out(apb2_clk_en), .cnt(apb2_cnt)
    );

    rcc_div_stage #(.CNT_W(4)) u_apb3 (
        .clk(sys_clk), .rst_n(sys_rst_n), .tick_in(ahb_clk_en), .term(apb3_term),
        .clr(apply), .tick_out(apb3_clk_en), .cnt(apb3_cnt)
    );

    rcc_div_stage #(.CNT_W(4)) u_apb4 (
        .clk(sys_clk), .rst_n(sys_rst_n), .tick_in(ahb_clk_en), .term(apb4_term),
        .clr(apply), .tick_out(apb4_clk_en), .cnt(apb4_cnt)
    );

    // Frame boundary: every counter sits on its terminal value at once,
    // which is exactly when cpu/ahb/apb1..4 strobes all fire together.
    assign boundary = (cpu_cnt == cpu_term) && (ahb_cnt == ahb_term) &&
                      (apb1_cnt == apb1_term) && (apb2_cnt == apb2_term) &&
                      (apb3_cnt == apb3_term) && (apb4_cnt == apb4_term);

    // Timer tick at twice the APB1 rate: low bits of apb1_cnt reach half-terminal
    assign tim_mask = apb1_term >> 1;

    // Timer-kernel strobe selection
    always_comb begin
        tim_clk_en = apb1_clk_en;
        if (act_ppre1[2]) begin
            tim_clk_en = ahb_clk_en & ((apb1_cnt & tim_mask) == tim_mask);
        end
    end

    // Handshake next-state and control decode
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        apply      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    capture    = 1'b1;
                    state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (boundary) begin
                    apply      = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign cfg_busy = (state == ST_PEND);
    assign cfg_ack  = apply;

    // Handshake state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shadow ratios captured on an accepted request
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shd_cpre  <= RST_CPRE;
            shd_hpre  <= RST_HPRE;
            shd_ppre1 <= RST_PPRE;
            shd_ppre2 <= RST_PPRE;
            shd_ppre3 <= RST_PPRE;
            shd_ppre4 <= RST_PPRE;
        end else if (capture) begin
            shd_cpre  <= cfg_cpre;
            shd_hpre  <= cfg_hpre;
            shd_ppre1 <= cfg_ppre1;
            shd_ppre2 <= cfg_ppre2;
            shd_ppre3 <= cfg_ppre3;
            shd_ppre4 <= cfg_ppre4;
        end
    end

    // Active ratios switch over at the frame boundary
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            act_cpre  <= RST_CPRE;
            act_hpre  <= RST_HPRE;
            act_ppre1 <= RST_PPRE;
            act_ppre2 <= RST_PPRE;
            act_ppre3 <= RST_PPRE;
            act_ppre4 <= RST_PPRE;
        end else if (apply) begin
            act_cpre  <= shd_cpre;
            act_hpre  <= shd_hpre;
            act_ppre1 <= shd_ppre1;
            act_ppre2 <= shd_ppre2;
            act_ppre3 <= shd_ppre3;
            act_ppre4 <= shd_ppre4;
        end
    end

endmodule

// File: tb/tb_rcc_bus_clk_prescaler.sv
// Self-checking bench for rcc_bus_clk_prescaler: table of ratio settings with
// measured strobe periods, hand sequences for the handshake corners, and a
// randomized run against a cycles-since-frame-start reference model.
module tb_rcc_bus_clk_prescaler;

    logic       sys_clk, sys_rst_n, cfg_valid;
    logic [3:0] cfg_cpre, cfg_hpre;
    logic [2:0] cfg_ppre1, cfg_ppre2, cfg_ppre3, cfg_ppre4;
    logic       cfg_busy, cfg_ack, cpu_clk_en, ahb_clk_en;
    logic       apb1_clk_en, apb2_clk_en, apb3_clk_en, apb4_clk_en, tim_clk_en;

    rcc_bus_clk_prescaler dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_valid(cfg_valid),
        .cfg_cpre(cfg_cpre), .cfg_hpre(cfg_hpre),
        .cfg_ppre1(cfg_ppre1), .cfg_ppre2(cfg_ppre2),
        .cfg_ppre3(cfg_ppre3), .cfg_ppre4(cfg_ppre4),
        .cfg_busy(cfg_busy), .cfg_ack(cfg_ack),
        .cpu_clk_en(cpu_clk_en), .ahb_clk_en(ahb_clk_en),
        .apb1_clk_en(apb1_clk_en), .apb2_clk_en(apb2_clk_en),
        .apb3_clk_en(apb3_clk_en), .apb4_clk_en(apb4_clk_en),
        .tim_clk_en(tim_clk_en)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // obs bit map: 0 cpu, 1 ahb, 2..5 apb1..4, 6 tim, 7 busy, 8 ack
    logic [8:0] obs;
    int first_k[9];
    int tick_n[9];

    // Reference model: every strobe is a pure function of cycles since the
    // last frame restart (reset or applied request).
    int n;
    int cdiv, hdiv, s_cdiv, s_hdiv;
    int pdiv[4];
    int s_pdiv[4];
    bit pend;

    typedef struct {
        logic [3:0] cpre, hpre;
        logic [2:0] p1, p2, p3, p4;
        int ack_wait;
        int per_cpu, per_ahb, per_p1, per_p2, per_p3, per_p4, per_tim;
    } vec_t;
    vec_t tbl[4];

    function automatic int dec4(input logic [3:0] code);
        if (!code[3]) return 1;
        return code[2] ? (64 << code[1:0]) : (2 << code[1:0]);
    endfunction

    function automatic int dec3(input logic [2:0] code);
        return code[2] ? (2 << code[1:0]) : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; pend = 0;
        cdiv = 1; hdiv = 1;
        for (int j = 0; j < 4; j++) pdiv[j] = 1;
    endtask

    function automatic logic [8:0] model_out();
        logic [8:0] e;
        int m, a;
        m = n + 1;
        a = cdiv * hdiv;
        e[0] = (m % cdiv) == 0;
        e[1] = (m % a) == 0;
        for (int j = 0; j < 4; j++) e[2+j] = (m % (a * pdiv[j])) == 0;
        e[6] = (pdiv[0] == 1) ? e[2] : ((m % (a * pdiv[0] / 2)) == 0);
        e[7] = pend;
        e[8] = pend && (&e[5:0]);
        return e;
    endfunction

    // Compare one cycle against the model, then advance both across a clock edge
    task automatic step();
        logic [8:0] e;
        #1;
        if (!sys_rst_n) model_reset();
        e = model_out();
        obs = {cfg_ack, cfg_busy, tim_clk_en, apb4_clk_en, apb3_clk_en,
               apb2_clk_en, apb1_clk_en, ahb_clk_en, cpu_clk_en};
        chk("cycle_outputs", obs, e);
        @(posedge sys_clk);
        if (sys_rst_n) begin
            if (pend && (&e[5:0])) begin
                cdiv = s_cdiv; hdiv = s_hdiv;
                for (int j = 0; j < 4; j++) pdiv[j] = s_pdiv[j];
                n = 0; pend = 0;
            end else begin
                n++;
                if (!pend && cfg_valid) begin
                    pend = 1;
                    s_cdiv = dec4(cfg_cpre); s_hdiv = dec4(cfg_hpre);
                    s_pdiv[0] = dec3(cfg_ppre1); s_pdiv[1] = dec3(cfg_ppre2);
                    s_pdiv[2] = dec3(cfg_ppre3); s_pdiv[3] = dec3(cfg_ppre4);
                end
            end
        end
        @(negedge sys_clk);
    endtask

    task automatic set_cfg(input logic [3:0] c, input logic [3:0] h,
                           input logic [2:0] p1, input logic [2:0] p2,
                           input logic [2:0] p3, input logic [2:0] p4);
        cfg_cpre = c; cfg_hpre = h;
        cfg_ppre1 = p1; cfg_ppre2 = p2; cfg_ppre3 = p3; cfg_ppre4 = p4;
    endtask

    // Issue a request and run until its ack (bounded); waited = cycles to ack
    task automatic do_request(input logic [3:0] c, input logic [3:0] h,
                              input logic [2:0] p1, input logic [2:0] p2,
                              input logic [2:0] p3, input logic [2:0] p4,
                              input int limit, output int waited);
        set_cfg(c, h, p1, p2, p3, p4);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!obs[8] && waited < limit);
        chk("ack_seen", obs[8], 1'b1);
    endtask

    // Record first tick position and tick count of each output over win cycles
    task automatic measure(input int win);
        for (int j = 0; j < 9; j++) begin first_k[j] = 0; tick_n[j] = 0; end
        for (int k = 1; k <= win; k++) begin
            step();
            for (int j = 0; j < 9; j++) begin
                if (obs[j]) begin
                    if (first_k[j] == 0) first_k[j] = k;
                    tick_n[j]++;
                end
            end
        end
    endtask

    initial begin
        int w, win, maxp;
        int per[7];

        tbl[0] = '{4'h8, 4'h9, 3'h4, 3'h0, 3'h0, 3'h0, 1, 2, 8, 16, 8, 8, 8, 8};
        tbl[1] = '{4'h8, 4'h8, 3'h7, 3'h0, 3'h0, 3'h0, 0, 2, 4, 64, 4, 4, 4, 32};
        tbl[2] = '{4'h0, 4'hB, 3'h5, 3'h6, 3'h7, 3'h4, 0, 1, 16, 64, 128, 256, 32, 32};
        tbl[3] = '{4'h0, 4'h0, 3'h0, 3'h0, 3'h0, 3'h0, 0, 1, 1, 1, 1, 1, 1, 1};

        sys_rst_n = 1'b0; cfg_valid = 1'b0;
        set_cfg(4'h0, 4'h0, 3'h0, 3'h0, 3'h0, 3'h0);
        model_reset();
        @(negedge sys_clk);

        // Reset state: all strobes high, no busy/ack
        step(); chk("reset_state", obs, 9'h07f);
        step();
        sys_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(); chk("default_all_ones", obs, 9'h07f);
        end

        // Table of ratio settings with expected periods
        for (int i = 0; i < 4; i++) begin
            do_request(tbl[i].cpre, tbl[i].hpre, tbl[i].p1, tbl[i].p2,
                       tbl[i].p3, tbl[i].p4, 5000, w);
            if (tbl[i].ack_wait != 0) chk("ack_latency", w, tbl[i].ack_wait);
            per[0] = tbl[i].per_cpu; per[1] = tbl[i].per_ahb;
            per[2] = tbl[i].per_p1;  per[3] = tbl[i].per_p2;
            per[4] = tbl[i].per_p3;  per[5] = tbl[i].per_p4;
            per[6] = tbl[i].per_tim;
            maxp = 1;
            for (int j = 0; j < 7; j++) if (per[j] > maxp) maxp = per[j];
            win = 2 * maxp;
            measure(win);
            for (int j = 0; j < 7; j++) begin
                chk($sformatf("tbl%0d_first_%0d", i, j), first_k[j], per[j]);
                chk($sformatf("tbl%0d_count_%0d", i, j), tick_n[j], win / per[j]);
            end
            chk($sformatf("tbl%0d_no_extra_ack", i), tick_n[8], 0);
        end

        // Second request during PEND is ignored; ack lands on an APB1 tick
        do_request(4'h8, 4'h8, 3'h7, 3'h0, 3'h0, 3'h0, 200, w);
        repeat ($urandom_range(0, 63)) step();
        set_cfg(4'h9, 4'h8, 3'h7, 3'h0, 3'h0, 3'h0);
        cfg_valid = 1'b1;
        step();
        set_cfg(4'hA, 4'h9, 3'h4, 3'h5, 3'h6, 3'h7);
        step();
        chk("busy_in_pend", obs[7], 1'b1);
        cfg_valid = 1'b0;
        w = 1;
        while (!obs[8] && w < 200) begin step(); w++; end
        chk("pend_ack_seen", obs[8], 1'b1);
        chk("ack_on_apb1_tick", obs[2], 1'b1);
        chk("ack_within_frame", w <= 64, 1'b1);
        measure(128);
        chk("first_req_cpu_period", first_k[0], 4);
        chk("first_req_apb1_period", first_k[2], 128);
        chk("single_ack", tick_n[8], 0);

        // Reset while PEND drops the request
        set_cfg(4'hB, 4'h0, 3'h0, 3'h0, 3'h0, 3'h0);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        chk("busy_before_reset", obs[7], 1'b1);
        sys_rst_n = 1'b0;
        step();
        chk("reset_drops_busy", obs, 9'h07f);
        step();
        sys_rst_n = 1'b1;
        measure(300);
        chk("dropped_no_ack", tick_n[8], 0);
        chk("dropped_cpu_all_ones", tick_n[0], 300);
        chk("dropped_apb1_first", first_k[2], 1);

        // Largest CPU/AHB ratios: long periods, counters wrap cleanly
        do_request(4'hF, 4'hF, 3'h0, 3'h0, 3'h0, 3'h0, 100, w);
        chk("max_ack_latency", w, 1);
        measure(2048);
        chk("max_cpu_first", first_k[0], 512);
        chk("max_cpu_count", tick_n[0], 4);
        chk("max_ahb_count", tick_n[1], 0);
        repeat (3000) step();
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;

        // Randomized traffic with bounded frame lengths
        for (int i = 0; i < 15000; i++) begin
            cfg_valid = ($urandom_range(0, 5) == 0);
            set_cfg(4'($urandom_range(0, 9)), 4'($urandom_range(0, 10)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            sys_rst_n = ($urandom_range(0, 2999) != 0);
            step();
        end
        sys_rst_n = 1'b1; cfg_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rcc_bus_clk_prescaler.md
Name: rcc_bus_clk_prescaler

Overview:
- Upstream stage of the bus/CPU clock controller.
- Runs entirely on sys_clk and produces one-cycle clock-enable strobes for the CPU, AHB, four APB domains and the timer kernel.
- The downstream gating stage ANDs these strobes with its sleep/deepsleep and allocation conditions.
- Divider ratios are reprogrammed through a valid/ack handshake. A new ratio takes effect only at a common frame boundary, so no domain ever sees a shortened period.

Parameters:
- RST_CPRE, 4'h0, reset CPU prescaler code (/1).
- RST_HPRE, 4'h0, reset AHB prescaler code (/1).
- RST_PPRE, 3'h0, reset code for all four APB prescalers (/1).

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  single-cycle request to load cfg_* values.
- cfg_cpre  in  4  CPU divide code, applied to sys_clk.
- cfg_hpre  in  4  AHB divide code, applied to CPU ticks.
- cfg_ppre1..cfg_ppre4  in  3 each  APB1..APB4 divide codes, applied to AHB ticks.
- cfg_busy  out  1  request pending; new requests are ignored while high.
- cfg_ack  out  1  one-cycle pulse in the cycle the new ratios are applied.
- cpu_clk_en  out  1  CPU tick.
- ahb_clk_en  out  1  AHB tick.
- apb1_clk_en..apb4_clk_en  out  1 each  APB ticks.
- tim_clk_en  out  1  timer-kernel tick, derived from APB1.

Behaviour:
- Code decode, 4-bit: 0xxx=/1, 1000=/2, 1001=/4, 1010=/8, 1011=/16, 1100=/64, 1101=/128, 1110=/256, 1111=/512.
- Code decode, 3-bit: 0xx=/1, 100=/2, 101=/4, 110=/8, 111=/16.
- Counters:
  - cpu_cnt (9b) increments every cycle.
  - ahb_cnt (9b) increments when cpu_clk_en=1.
  - apbN_cnt (4b) increments when ahb_clk_en=1.
  - Each counter wraps to 0 at div-1; with /1 it stays at 0.
- Strobes (all combinational from registered state, no extra latency):
  - cpu_clk_en = (cpu_cnt == cdiv-1).
  - ahb_clk_en = cpu_clk_en & (ahb_cnt == hdiv-1).
  - apbN_clk_en = ahb_clk_en & (apbN_cnt == pNdiv-1).
  - With /1 a strobe equals its parent strobe; with all /1, every strobe is constantly 1.
- tim_clk_en:
  - pdiv1 == 1: equals apb1_clk_en.
  - otherwise: ahb_clk_en & ((apb1_cnt mod (pdiv1/2)) == pdiv1/2-1), i.e. twice the APB1 rate and coincident with every apb1_clk_en.
- Reset:
  - All counters 0; active ratios = RST_* values; cfg_busy=0, cfg_ack=0.
  - With default parameters all strobes read 1 during and after reset.
- Handshake and switching:
  - States: IDLE, PEND.
  - IDLE: cfg_valid=1 captures all cfg_* into shadow registers and moves to PEND; cfg_busy=1 from the next cycle.
  - PEND: cfg_valid is ignored and the shadow registers are unchanged.
  - Frame boundary = cycle where cpu_clk_en, ahb_clk_en and all four apbN_clk_en are simultaneously 1. It always recurs, at latest after cdiv*hdiv*max(pNdiv) cycles.
  - At the frame boundary in PEND: shadow copied to active, all counters cleared, cfg_ack=1 for one cycle, return to IDLE (cfg_busy=0 the following cycle).
  - The boundary cycle's strobes use the old ratios; the next cycle uses the new ratios from count 0.
- cfg_valid in the same cycle as cfg_ack: ignored, because the state is still PEND.
- Reset asserted mid-PEND: request dropped, RST_* ratios restored.
- Request whose values equal the active ratios: still waits for a boundary and acks. No short path.

Decomposition:
- Package rcc_pkg:
  - 4-bit and 3-bit code-to-divisor decode functions (returning the divisor and the counter terminal value).
  - Code constants RCC_DIV1, RCC_DIV2 … RCC_DIV512.
  - The IDLE/PEND state enum.
- One sub-module rcc_div_stage:
  - Parameter CNT_W; inputs tick_in, term, clr.
  - Outputs tick_out and cnt.
  - Instantiated six times: CPU, AHB, APB1..4.
- Top level holds the shadow/active registers, the FSM and the tim_clk_en logic.

Test Plan:
- Reset with defaults -> every strobe constantly 1; cfg_busy=0; cfg_ack never asserts.
- cfg_valid with cpre=1000, hpre=1001, ppre1=100, ppre2..4=0xx from all-/1 -> ack in the cycle after the request (boundary is immediate). Then cpu_clk_en every 2 cycles, ahb every 8, apb1 every 16, apb2..4 every 8, tim_clk_en every 8 cycles and coincident with each apb1 tick.
- From cpre=1000, hpre=1000, ppre1=111:
  - request at an arbitrary phase -> cfg_busy high until the 64-cycle frame boundary.
  - cfg_ack exactly at the cycle where apb1_clk_en=1.
  - No strobe interval shorter than its old period before ack.
- A second cfg_valid during PEND carrying different codes -> ignored; the first request's values are applied; exactly one cfg_ack.
- sys_rst_n asserted while PEND -> cfg_busy=0 immediately, strobes revert to RST_* ratios, and no cfg_ack ever appears for the dropped request.
- cpre=1111, hpre=1111 -> cpu_clk_en period 512, ahb_clk_en period 262144; counters wrap with no overflow.
